// File: rtl/mux_arbiter_32bit.sv
// Round-robin packet arbiter for a shared 2:1 datapath mux with a registered output stage.
// Requester A is routed when sel=1 and B when sel=0. A grant is held for a whole packet.
module mux_arbiter_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             sel,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  output logic             y_src,
  input  logic             y_ready
);

  typedef enum logic [1:0] {StIdle, StGrantA, StGrantB} state_e;

  state_e state_q, state_d;
  // 1 = A wins a tie, 0 = B wins a tie.
  logic   pri_q, pri_d;

  logic   out_free;
  logic   a_acc;
  logic   b_acc;

  // Handshake decode: readies depend combinationally on y_ready through out_free.
  always_comb begin
    out_free = !y_valid || y_ready;
    sel      = (state_q == StGrantA);
    a_ready  = (state_q == StGrantA) && out_free;
    b_ready  = (state_q == StGrantB) && out_free;
    a_acc    = a_valid && a_ready;
    b_acc    = b_valid && b_ready;
  end

  // Next-state and priority: arbitrate from idle, re-arbitrate when a last beat is accepted.
  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    unique case (state_q)
      StIdle: begin
        if (a_valid && b_valid) begin
          state_d = pri_q ? StGrantA : StGrantB;
        end else if (a_valid) begin
          state_d = StGrantA;
        end else if (b_valid) begin
          state_d = StGrantB;
        end
      end
      StGrantA: begin
        if (a_acc && a_last) begin
          pri_d = 1'b0;
          if (b_valid) begin
            state_d = StGrantB;
          end else if (a_valid) begin
            state_d = StGrantA;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGrantB: begin
        if (b_acc && b_last) begin
          pri_d = 1'b1;
          if (a_valid) begin
            state_d = StGrantA;
          end else if (b_valid) begin
            state_d = StGrantB;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Arbiter state register; reset restarts from idle with A priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pri_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
    end
  end

  // Output stage: load on an accepted beat, drop valid once the held beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
      y_src   <= 1'b0;
    end else if (a_acc || b_acc) begin
      y_valid <= 1'b1;
      y_data  <= sel ? a_data : b_data;
      y_last  <= sel ? a_last : b_last;
      y_src   <= sel;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter_32bit.sv
// Directed self-checking bench for mux_arbiter_32bit.
module tb_mux_arbiter_32bit;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [31:0] a_data;
  logic        a_last;
  logic        a_ready;
  logic        b_valid;
  logic [31:0] b_data;
  logic        b_last;
  logic        b_ready;
  logic        sel;
  logic        y_valid;
  logic [31:0] y_data;
  logic        y_last;
  logic        y_src;
  logic        y_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Completed output beats: {src, last, data}.
  logic [33:0] mon_q[$];

  mux_arbiter_32bit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .sel     (sel),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_src   (y_src),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each beat that the downstream takes at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && y_valid && y_ready) mon_q.push_back({y_src, y_last, y_data});
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Compare {sel, a_ready, b_ready} mid-cycle.
  task automatic chk_hs(input string tag, input logic es, input logic ea, input logic eb);
    @(negedge clk);
    check_eq(tag, {61'd0, sel, a_ready, b_ready}, {61'd0, es, ea, eb});
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [33:0] exp);
    logic [33:0] got;
    got = (idx < mon_q.size()) ? mon_q[idx] : '1;
    check_eq(tag, {30'd0, got}, {30'd0, exp});
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_data  = '0;
    a_last  = 1'b0;
    b_valid = 1'b0;
    b_data  = '0;
    b_last  = 1'b0;
    y_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int unsigned na;
    int unsigned nb;
    int unsigned nacc;
    logic        acc_a;
    logic        acc_b;

    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_data  = '0;
    a_last  = 1'b0;
    b_valid = 1'b0;
    b_data  = '0;
    b_last  = 1'b0;
    y_ready = 1'b0;

    // Reset with both requesters valid: everything quiet, then A wins first.
    #2;
    a_valid = 1'b1;
    a_data  = 32'h1234_5678;
    b_valid = 1'b1;
    b_data  = 32'h8765_4321;
    y_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {26'd0, y_valid, y_last, y_src, sel, a_ready, b_ready, y_data},
             64'd0);
    rst_n = 1'b1;
    chk_hs("reset_release_grant_a", 1'b1, 1'b1, 1'b0);

    // Single beat from A.
    apply_reset();
    a_valid = 1'b1;
    a_data  = 32'hDEAD_BEEF;
    a_last  = 1'b1;
    chk_hs("single_c0_idle", 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk_hs("single_c1_accept", 1'b1, 1'b1, 1'b0);
    next_cycle();
    a_valid = 1'b0;
    @(negedge clk);
    check_eq("single_y_valid", {63'd0, y_valid}, 64'd1);
    check_eq("single_y_data", {32'd0, y_data}, 64'hDEAD_BEEF);
    check_eq("single_y_last_src", {62'd0, y_last, y_src}, 64'd3);

    // Packet lock: A's three beats, then B immediately.
    apply_reset();
    a_valid = 1'b1;
    a_data  = 32'h1;
    a_last  = 1'b0;
    b_valid = 1'b1;
    b_data  = 32'hB0;
    b_last  = 1'b1;
    chk_hs("lock_c0", 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk_hs("lock_c1", 1'b1, 1'b1, 1'b0);
    next_cycle();
    a_data = 32'h2;
    chk_hs("lock_c2", 1'b1, 1'b1, 1'b0);
    next_cycle();
    a_data = 32'h3;
    a_last = 1'b1;
    chk_hs("lock_c3", 1'b1, 1'b1, 1'b0);
    next_cycle();
    a_valid = 1'b0;
    chk_hs("lock_c4_handoff_b", 1'b0, 1'b0, 1'b1);
    next_cycle();
    b_valid = 1'b0;
    repeat (3) next_cycle();
    check_eq("lock_count", 64'(mon_q.size()), 64'd4);
    chk_beat("lock_beat0", 0, {1'b1, 1'b0, 32'h1});
    chk_beat("lock_beat1", 1, {1'b1, 1'b0, 32'h2});
    chk_beat("lock_beat2", 2, {1'b1, 1'b1, 32'h3});
    chk_beat("lock_beat3", 3, {1'b0, 1'b1, 32'hB0});

    // Backpressure for four cycles in the middle of an A packet.
    apply_reset();
    a_valid = 1'b1;
    a_data  = 32'h10;
    a_last  = 1'b0;
    next_cycle();
    chk_hs("bp_c1", 1'b1, 1'b1, 1'b0);
    next_cycle();
    y_ready = 1'b0;
    a_data  = 32'h11;
    for (int i = 0; i < 4; i++) begin
      chk_hs($sformatf("bp_stall%0d_ready", i), 1'b1, 1'b0, 1'b0);
      check_eq($sformatf("bp_stall%0d_data", i), {31'd0, y_valid, y_data}, {31'd0, 1'b1, 32'h10});
      next_cycle();
    end
    y_ready = 1'b1;
    chk_hs("bp_resume_ready", 1'b1, 1'b1, 1'b0);
    next_cycle();
    a_data = 32'h12;
    a_last = 1'b1;
    @(negedge clk);
    check_eq("bp_next_beat", {31'd0, y_valid, y_data}, {31'd0, 1'b1, 32'h11});
    next_cycle();
    a_valid = 1'b0;
    repeat (3) next_cycle();
    check_eq("bp_count", 64'(mon_q.size()), 64'd3);
    chk_beat("bp_beat0", 0, {1'b1, 1'b0, 32'h10});
    chk_beat("bp_beat1", 1, {1'b1, 1'b0, 32'h11});
    chk_beat("bp_beat2", 2, {1'b1, 1'b1, 32'h12});

    // Round-robin fairness with single-beat packets from both sides.
    apply_reset();
    na      = 0;
    nb      = 0;
    nacc    = 0;
    a_valid = 1'b1;
    a_last  = 1'b1;
    a_data  = 32'hA0;
    b_valid = 1'b1;
    b_last  = 1'b1;
    b_data  = 32'hB0;
    for (int c = 0; c < 40 && nacc < 8; c++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      next_cycle();
      if (acc_a) begin
        na++;
        nacc++;
        a_data = 32'hA0 + na;
      end
      if (acc_b) begin
        nb++;
        nacc++;
        b_data = 32'hB0 + nb;
      end
      if (nacc >= 8) begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (3) next_cycle();
    check_eq("rr_count", 64'(mon_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ed;
      ed = (i % 2 == 0) ? 32'hA0 + 32'(i / 2) : 32'hB0 + 32'(i / 2);
      chk_beat($sformatf("rr_pkt%0d", i), i, {(i % 2 == 0), 1'b1, ed});
    end

    // Reset in the middle of a four-beat B packet.
    apply_reset();
    b_valid = 1'b1;
    b_data  = 32'hC0;
    b_last  = 1'b0;
    next_cycle();
    chk_hs("mid_c1_grant_b", 1'b0, 1'b0, 1'b1);
    next_cycle();
    b_data = 32'hC1;
    next_cycle();
    rst_n   = 1'b0;
    a_valid = 1'b1;
    a_data  = 32'hAA;
    a_last  = 1'b1;
    b_data  = 32'hC2;
    #1;
    check_eq("mid_reset_outputs", {26'd0, y_valid, y_last, y_src, sel, a_ready, b_ready, y_data},
             64'd0);
    check_eq("mid_emitted_before_reset", 64'(mon_q.size()), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_q.delete();
    next_cycle();
    chk_hs("mid_after_release_a", 1'b1, 1'b1, 1'b0);
    next_cycle();
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_first_beat_a", {31'd0, y_src, y_data}, {31'd0, 1'b1, 32'hAA});
    check_eq("mid_first_beat_valid", {63'd0, y_valid}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
